id_scoreboard: RTL and testbench

- Parametrised hazard/forwarding scoreboard for the decode stage; successor to the fixed EX/ME/WB compare-based forwarding.
- Tracks every in-flight register write by age and result class (ALU, MEM), so deeper pipelines and multi-cycle loads need no extra compare logic.
- Sits beside the ID pipeline register. Drives the ID stall and the per-operand forwarding mux selects; the EX/ME/WB data buses stay outside this block.

---
 rtl/id_scoreboard_pkg.sv | 22 ++
 rtl/id_sb_lookup.sv | 30 +++
 rtl/id_scoreboard.sv | 125 ++++++++++++
 tb/tb_id_scoreboard.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_scoreboard_pkg.sv
// Shared encodings and entry field widths for the ID-stage hazard/forwarding scoreboard.
package id_scoreboard_pkg;

  localparam int DEST_SRC_W = 2;

  typedef enum logic [DEST_SRC_W-1:0] {
    DEST_SRC_NONE = 2'd0,
    DEST_SRC_ALU  = 2'd1,
    DEST_SRC_MEM  = 2'd2
  } dest_src_e;

  localparam int FWD_SEL_RF = 0;

  localparam int SB_VALID_W   = 1;
  localparam int SB_IS_LOAD_W = 1;

  // Age counts 0..depth-1; keep at least one bit for a single-stage pipe.
  function automatic int sb_age_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/id_sb_lookup.sv
// Per-operand hazard and forward-select decode from one scoreboard entry.
module id_sb_lookup
  import id_scoreboard_pkg::*;
#(
  parameter int LOAD_LAT  = 1,
  parameter int ALU_LAT   = 0,
  parameter int AGE_W     = 2,
  parameter int FWD_SEL_W = 2
) (
  input  logic                 use_i,
  input  logic                 src_nz_i,
  input  logic                 valid_i,
  input  logic [AGE_W-1:0]     age_i,
  input  logic                 is_load_i,
  output logic                 hazard_o,
  output logic [FWD_SEL_W-1:0] fwd_sel_o
);

  logic live;
  int   age_int;
  int   lat;

  assign live    = use_i & src_nz_i & valid_i;
  assign age_int = int'(age_i);
  assign lat     = is_load_i ? LOAD_LAT : ALU_LAT;

  assign hazard_o  = live & (age_int < lat);
  assign fwd_sel_o = live ? (FWD_SEL_W'(age_i) + FWD_SEL_W'(1)) : FWD_SEL_W'(FWD_SEL_RF);

endmodule

// File: rtl/id_scoreboard.sv
// ID-stage scoreboard: tracks in-flight register writes by age and class, drives stall and forward selects.
// Defining ID_SCOREBOARD_PERF_EN adds the o_stall_cnt stall-cycle counter.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int  NUM_REGS  = 32,
  parameter int  REG_IDX_W = 5,
  parameter int  DEPTH     = 3,
  parameter int  LOAD_LAT  = 1,
  parameter int  ALU_LAT   = 0,
  localparam int FWD_SEL_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  i_hold,
  input  logic                  i_flush,
  input  logic                  i_issue_valid,
  input  logic [REG_IDX_W-1:0]  i_dest_reg,
  input  logic [DEST_SRC_W-1:0] i_dest_src,
  input  logic [REG_IDX_W-1:0]  i_src_a,
  input  logic [REG_IDX_W-1:0]  i_src_b,
  input  logic                  i_use_a,
  input  logic                  i_use_b,
  output logic                  o_stall,
  output logic                  o_issue,
  output logic [FWD_SEL_W-1:0]  o_fwd_sel_a,
  output logic [FWD_SEL_W-1:0]  o_fwd_sel_b
`ifdef ID_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]           o_stall_cnt
`endif
);

  localparam int               AGE_W    = sb_age_w(DEPTH);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(DEPTH - 1);

  logic [NUM_REGS-1:0] valid_q, valid_d;
  logic [NUM_REGS-1:0] load_q, load_d;
  logic [AGE_W-1:0]    age_q [NUM_REGS];
  logic [AGE_W-1:0]    age_d [NUM_REGS];
  logic                haz_a, haz_b;
  logic                wr_en;

  id_sb_lookup #(
    .LOAD_LAT (LOAD_LAT),
    .ALU_LAT  (ALU_LAT),
    .AGE_W    (AGE_W),
    .FWD_SEL_W(FWD_SEL_W)
  ) u_lookup_a (
    .use_i    (i_use_a),
    .src_nz_i (i_src_a != '0),
    .valid_i  (valid_q[i_src_a]),
    .age_i    (age_q[i_src_a]),
    .is_load_i(load_q[i_src_a]),
    .hazard_o (haz_a),
    .fwd_sel_o(o_fwd_sel_a)
  );

  id_sb_lookup #(
    .LOAD_LAT (LOAD_LAT),
    .ALU_LAT  (ALU_LAT),
    .AGE_W    (AGE_W),
    .FWD_SEL_W(FWD_SEL_W)
  ) u_lookup_b (
    .use_i    (i_use_b),
    .src_nz_i (i_src_b != '0),
    .valid_i  (valid_q[i_src_b]),
    .age_i    (age_q[i_src_b]),
    .is_load_i(load_q[i_src_b]),
    .hazard_o (haz_b),
    .fwd_sel_o(o_fwd_sel_b)
  );

  assign o_stall = haz_a | haz_b;
  assign o_issue = i_issue_valid & ~o_stall & ~i_flush & ~i_hold;
  assign wr_en   = o_issue & (i_dest_reg != '0) & (i_dest_src != DEST_SRC_NONE);

  // Hazards are judged on the old entries above, so a new write may replace its own source entry.
  always_comb begin
    valid_d = valid_q;
    load_d  = load_q;
    age_d   = age_q;
    if (!i_hold) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (valid_q[r]) begin
          if (age_q[r] == AGE_LAST) valid_d[r] = 1'b0;
          else                      age_d[r]   = age_q[r] + AGE_W'(1);
        end
      end
      if (wr_en) begin
        valid_d[i_dest_reg] = 1'b1;
        age_d[i_dest_reg]   = '0;
        load_d[i_dest_reg]  = (i_dest_src == DEST_SRC_MEM);
      end
    end
    valid_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
      load_q  <= '0;
      for (int r = 0; r < NUM_REGS; r++) age_q[r] <= '0;
    end else begin
      valid_q <= valid_d;
      load_q  <= load_d;
      age_q   <= age_d;
    end
  end

`ifdef ID_SCOREBOARD_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt_q <= '0;
    end else if (o_stall & ~i_hold & i_issue_valid & ~(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed vector tables (default and LOAD_LAT=2 builds) plus
// random traffic against a pipeline-queue reference model.
module tb_id_scoreboard;
  import id_scoreboard_pkg::*;

  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
  localparam int ALU_LAT  = 0;
  localparam int N = int'(DEST_SRC_NONE);
  localparam int A = int'(DEST_SRC_ALU);
  localparam int M = int'(DEST_SRC_MEM);

  logic       clk = 1'b0;
  logic       clr, i_hold, i_flush, i_issue_valid;
  logic [4:0] i_dest_reg, i_src_a, i_src_b;
  logic [1:0] i_dest_src;
  logic       i_use_a, i_use_b;
  logic       o_stall, o_issue, o_stall2, o_issue2;
  logic [1:0] o_fwd_sel_a, o_fwd_sel_b, o_fwd_sel_a2, o_fwd_sel_b2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_scoreboard #(.NUM_REGS(32), .REG_IDX_W(5), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .clr(clr), .i_hold(i_hold), .i_flush(i_flush), .i_issue_valid(i_issue_valid),
    .i_dest_reg(i_dest_reg), .i_dest_src(i_dest_src), .i_src_a(i_src_a), .i_src_b(i_src_b),
    .i_use_a(i_use_a), .i_use_b(i_use_b), .o_stall(o_stall), .o_issue(o_issue),
    .o_fwd_sel_a(o_fwd_sel_a), .o_fwd_sel_b(o_fwd_sel_b)
  );

  id_scoreboard #(.NUM_REGS(32), .REG_IDX_W(5), .DEPTH(DEPTH), .LOAD_LAT(2), .ALU_LAT(ALU_LAT)) dut2 (
    .clk(clk), .clr(clr), .i_hold(i_hold), .i_flush(i_flush), .i_issue_valid(i_issue_valid),
    .i_dest_reg(i_dest_reg), .i_dest_src(i_dest_src), .i_src_a(i_src_a), .i_src_b(i_src_b),
    .i_use_a(i_use_a), .i_use_b(i_use_b), .o_stall(o_stall2), .o_issue(o_issue2),
    .o_fwd_sel_a(o_fwd_sel_a2), .o_fwd_sel_b(o_fwd_sel_b2)
  );

  typedef struct {
    logic       clr, hold, flush, iv;
    logic [4:0] dest;
    logic [1:0] dsrc;
    logic [4:0] sa, sb;
    logic       ua, ub;
    logic       e_stall, e_issue;
    logic [1:0] e_fa, e_fb;
  } vec_t;

  vec_t vecs1[$];
  vec_t vecs2[$];

  function automatic vec_t mk(input int c, h, f, iv, dest, dsrc, sa, ua, sb, ub, es, ei, efa, efb);
    vec_t v;
    v.clr = 1'(c);  v.hold = 1'(h);  v.flush = 1'(f);  v.iv = 1'(iv);
    v.dest = 5'(dest);  v.dsrc = 2'(dsrc);
    v.sa = 5'(sa);  v.ua = 1'(ua);  v.sb = 5'(sb);  v.ub = 1'(ub);
    v.e_stall = 1'(es);  v.e_issue = 1'(ei);  v.e_fa = 2'(efa);  v.e_fb = 2'(efb);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    clr = v.clr;  i_hold = v.hold;  i_flush = v.flush;  i_issue_valid = v.iv;
    i_dest_reg = v.dest;  i_dest_src = v.dsrc;
    i_src_a = v.sa;  i_use_a = v.ua;  i_src_b = v.sb;  i_use_b = v.ub;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    drive(mk(1, 0,0,0, 0,N, 0,0,0,0, 0,0,0,0));
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Reference model: a list of issued producers, youngest first, each with the
  // pipeline stage it currently occupies (1 = EX). Visible in the register file past DEPTH.
  typedef struct {
    logic [4:0] dest;
    bit         is_load;
    int         stage;
  } rec_t;
  rec_t m_q[$];

  function automatic int m_find(input logic [4:0] src, input logic u);
    int r = -1;
    if (!u || src == 5'd0) return -1;
    for (int i = m_q.size() - 1; i >= 0; i--)
      if (m_q[i].dest == src) r = i;
    return r;
  endfunction

  function automatic logic m_haz(input logic [4:0] src, input logic u);
    int r = m_find(src, u);
    if (r < 0) return 1'b0;
    return (m_q[r].stage - 1) < (m_q[r].is_load ? LOAD_LAT : ALU_LAT);
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] src, input logic u);
    int r = m_find(src, u);
    return (r < 0) ? 32'd0 : 32'(m_q[r].stage);
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      m_q.delete();
    end else if (!i_hold) begin
      automatic bit iss = i_issue_valid && !i_flush &&
                          !(m_haz(i_src_a, i_use_a) || m_haz(i_src_b, i_use_b));
      foreach (m_q[i]) m_q[i].stage = m_q[i].stage + 1;
      while (m_q.size() > 0 && m_q[m_q.size() - 1].stage > DEPTH) void'(m_q.pop_back());
      if (iss && i_dest_reg != 5'd0 && i_dest_src != 2'(N)) begin
        rec_t rec;
        rec.dest = i_dest_reg;
        rec.is_load = (i_dest_src == 2'(M));
        rec.stage = 1;
        m_q.push_front(rec);
      end
    end
  end

  logic        e_stall, e_issue;
  logic [31:0] e_fa, e_fb;

  initial begin
    // default build:  c  h  f iv  dst dsrc  sa ua  sb ub   st is fa fb
    vecs1.push_back(mk(0, 0,0,0,  0,N,    0,0,  0,0,   0,0,0,0));
    vecs1.push_back(mk(0, 0,0,1,  0,N,    5,1,  6,1,   0,1,0,0));
    // load r5, dependent consumer stalls one cycle then forwards from ME
    vecs1.push_back(mk(0, 0,0,1,  5,M,    0,0,  0,0,   0,1,0,0));
    vecs1.push_back(mk(0, 0,0,1,  0,N,    5,1,  0,0,   1,0,1,0));
    vecs1.push_back(mk(0, 0,0,1,  0,N,    5,1,  0,0,   0,1,2,0));
    repeat (3) vecs1.push_back(mk(0, 0,0,0, 0,N, 0,0,0,0, 0,0,0,0));
    // ALU r3, consumers at distance 1..4
    vecs1.push_back(mk(0, 0,0,1,  3,A,    0,0,  0,0,   0,1,0,0));
    vecs1.push_back(mk(0, 0,0,1,  0,N,    3,1,  3,0,   0,1,1,0));
    vecs1.push_back(mk(0, 0,0,1,  0,N,    1,1,  3,1,   0,1,0,2));
    vecs1.push_back(mk(0, 0,0,1,  0,N,    3,1,  0,0,   0,1,3,0));
    vecs1.push_back(mk(0, 0,0,1,  0,N,    3,1,  3,1,   0,1,0,0));
    // load to x0 creates nothing
    vecs1.push_back(mk(0, 0,0,1,  0,M,    0,0,  0,0,   0,1,0,0));
    vecs1.push_back(mk(0, 0,0,1,  0,N,    0,1,  0,1,   0,1,0,0));
    // WAW: ALU r7 replaces pending load r7
    vecs1.push_back(mk(0, 0,0,1,  7,M,    0,0,  0,0,   0,1,0,0));
    vecs1.push_back(mk(0, 0,0,1,  7,A,    0,0,  0,0,   0,1,0,0));
    vecs1.push_back(mk(0, 0,0,1,  0,N,    7,1,  7,1,   0,1,1,1));
    repeat (3) vecs1.push_back(mk(0, 0,0,0, 0,N, 0,0,0,0, 0,0,0,0));
    // load r9, hold freezes the stall, flush during stall, release
    vecs1.push_back(mk(0, 0,0,1,  9,M,    0,0,  0,0,   0,1,0,0));
    repeat (3) vecs1.push_back(mk(0, 1,0,1, 0,N, 9,1,0,0, 1,0,1,0));
    vecs1.push_back(mk(0, 0,1,1,  0,N,    9,1,  0,0,   1,0,1,0));
    vecs1.push_back(mk(0, 0,0,1,  0,N,    9,1,  0,0,   0,1,2,0));
    vecs1.push_back(mk(0, 0,0,1,  0,N,    9,1,  9,1,   0,1,3,3));
    vecs1.push_back(mk(0, 0,0,1,  0,N,    9,1,  0,0,   0,1,0,0));
    // held and flushed producers never create entries
    vecs1.push_back(mk(0, 1,0,1, 11,A,    0,0,  0,0,   0,0,0,0));
    vecs1.push_back(mk(0, 0,0,1,  0,N,   11,1,  0,0,   0,1,0,0));
    vecs1.push_back(mk(0, 0,1,1, 10,A,    0,0,  0,0,   0,0,0,0));
    vecs1.push_back(mk(0, 0,0,1,  0,N,   10,1,  0,0,   0,1,0,0));
    // source equals own destination
    vecs1.push_back(mk(0, 0,0,1, 12,M,    0,0,  0,0,   0,1,0,0));
    vecs1.push_back(mk(0, 0,0,1, 12,M,   12,1,  0,0,   1,0,1,0));
    vecs1.push_back(mk(0, 0,0,1, 12,M,   12,1,  0,0,   0,1,2,0));
    vecs1.push_back(mk(0, 0,0,1,  0,N,    0,0, 12,1,   1,0,0,1));
    vecs1.push_back(mk(0, 0,0,1,  0,N,    0,0, 12,1,   0,1,0,2));

    // LOAD_LAT=2 build: two stall cycles, then clr mid-stall (alone and with hold)
    vecs2.push_back(mk(0, 0,0,1,  4,M,    0,0,  0,0,   0,1,0,0));
    vecs2.push_back(mk(0, 0,0,1,  0,N,    4,1,  0,0,   1,0,1,0));
    vecs2.push_back(mk(0, 0,0,1,  0,N,    4,1,  0,0,   1,0,2,0));
    vecs2.push_back(mk(0, 0,0,1,  0,N,    4,1,  0,0,   0,1,3,0));
    vecs2.push_back(mk(0, 0,0,1,  4,M,    0,0,  0,0,   0,1,0,0));
    vecs2.push_back(mk(0, 0,0,1,  0,N,    4,1,  4,1,   1,0,1,1));
    vecs2.push_back(mk(1, 0,0,1,  0,N,    4,1,  4,1,   1,0,2,2));
    vecs2.push_back(mk(0, 0,0,1,  0,N,    4,1,  4,1,   0,1,0,0));
    vecs2.push_back(mk(0, 0,0,1,  4,M,    0,0,  0,0,   0,1,0,0));
    vecs2.push_back(mk(1, 1,0,1,  0,N,    4,1,  0,0,   1,0,1,0));
    vecs2.push_back(mk(0, 0,0,1,  0,N,    4,1,  0,0,   0,1,0,0));

    drive(mk(1, 0,0,0, 0,N, 0,0,0,0, 0,0,0,0));
    repeat (2) @(negedge clk);
    clr = 1'b0;

    foreach (vecs1[i]) begin
      @(negedge clk);
      drive(vecs1[i]);
      #1;
      check($sformatf("v%0d_stall", i), 32'(o_stall),     32'(vecs1[i].e_stall));
      check($sformatf("v%0d_issue", i), 32'(o_issue),     32'(vecs1[i].e_issue));
      check($sformatf("v%0d_fwd_a", i), 32'(o_fwd_sel_a), 32'(vecs1[i].e_fa));
      check($sformatf("v%0d_fwd_b", i), 32'(o_fwd_sel_b), 32'(vecs1[i].e_fb));
    end

    pulse_clr();
    foreach (vecs2[i]) begin
      @(negedge clk);
      drive(vecs2[i]);
      #1;
      check($sformatf("ll2_v%0d_stall", i), 32'(o_stall2),     32'(vecs2[i].e_stall));
      check($sformatf("ll2_v%0d_issue", i), 32'(o_issue2),     32'(vecs2[i].e_issue));
      check($sformatf("ll2_v%0d_fwd_a", i), 32'(o_fwd_sel_a2), 32'(vecs2[i].e_fa));
      check($sformatf("ll2_v%0d_fwd_b", i), 32'(o_fwd_sel_b2), 32'(vecs2[i].e_fb));
    end

    pulse_clr();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      clr           = ($urandom_range(0, 63) == 0);
      i_hold        = ($urandom_range(0, 7) == 0);
      i_flush       = ($urandom_range(0, 7) == 0);
      i_issue_valid = ($urandom_range(0, 5) != 0);
      i_dest_reg    = 5'($urandom_range(0, 7));
      i_dest_src    = 2'($urandom_range(0, 2));
      i_src_a       = 5'($urandom_range(0, 7));
      i_src_b       = 5'($urandom_range(0, 7));
      i_use_a       = ($urandom_range(0, 3) != 0);
      i_use_b       = ($urandom_range(0, 1) != 0);
      #1;
      e_stall = m_haz(i_src_a, i_use_a) | m_haz(i_src_b, i_use_b);
      e_issue = i_issue_valid & ~e_stall & ~i_flush & ~i_hold;
      e_fa    = m_fwd(i_src_a, i_use_a);
      e_fb    = m_fwd(i_src_b, i_use_b);
      check($sformatf("rnd%0d_stall", n), 32'(o_stall),     32'(e_stall));
      check($sformatf("rnd%0d_issue", n), 32'(o_issue),     32'(e_issue));
      check($sformatf("rnd%0d_fwd_a", n), 32'(o_fwd_sel_a), e_fa);
      check($sformatf("rnd%0d_fwd_b", n), 32'(o_fwd_sel_b), e_fb);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
